// File: rtl/scs8hd_arb3_rr.sv
// scs8hd_arb3_rr -- three-requester round-robin arbiter with a hold timeout.
//
// One requester at a time is granted a shared resource. The winner is picked
// round-robin, starting from the requester after the most recent winner. A
// grant is held until the holder finishes (DONE), drops its request, the
// global enable falls, or the hold limit MAX_HOLD is reached. Every release
// except a revoke passes through a one-cycle REL state.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles a grant may be held (1..15)
// Ports
//   CLK     clock, rising edge
//   RESETB  asynchronous active-low reset
//   REQ     [2:0] request vector
//   B1      resource available (looked at only when issuing a grant)
//   C1      global enable; low revokes any grant
//   DONE    current holder releases the resource
//   GNT     [2:0] registered one-hot grant, or zero
//   BUSYB   registered, low exactly when GNT is non-zero
//   LAST    [1:0] index of the most recent winner
//   TMO     one-cycle pulse on a release caused only by the hold limit
module scs8hd_arb3_rr #(
  parameter int MAX_HOLD = 15
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic [2:0] REQ,
  input  logic       B1,
  input  logic       C1,
  input  logic       DONE,
  output logic [2:0] GNT,
  output logic       BUSYB,
  output logic [1:0] LAST,
  output logic       TMO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2
  } state_t;

  // Counter value seen on the edge that ends the MAX_HOLD-th grant cycle.
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] gnt_nxt;
  logic       busyb_nxt;
  logic [1:0] last_nxt;
  logic       tmo_nxt;

  // Round-robin search order, starting one past the previous winner.
  logic [1:0] p0, p1, p2;
  logic [1:0] win;
  logic       holder_req;

  always_comb begin
    case (LAST)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (REQ[p0])      win = p0;
    else if (REQ[p1]) win = p1;
    else              win = p2;
  end

  // GNT is one-hot while holding, so this picks out the holder's request.
  assign holder_req = |(REQ & GNT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = GNT;
    busyb_nxt = BUSYB;
    last_nxt  = LAST;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt   = 3'b000;
        busyb_nxt = 1'b1;
        if (C1 && B1 && (REQ != 3'b000)) begin
          state_nxt = HOLD;
          gnt_nxt   = 3'b001 << win;
          busyb_nxt = 1'b0;
          last_nxt  = win;
          cnt_nxt   = 4'd0;
        end
      end
      HOLD: begin
        if (!C1) begin
          state_nxt = IDLE;
          gnt_nxt   = 3'b000;
          busyb_nxt = 1'b1;
        end else if (DONE || !holder_req) begin
          state_nxt = REL;
          gnt_nxt   = 3'b000;
          busyb_nxt = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = REL;
          gnt_nxt   = 3'b000;
          busyb_nxt = 1'b1;
          tmo_nxt   = 1'b1;
        end else if (cnt != 4'd15) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      REL: begin
        // Requests are deliberately ignored here: forces an idle gap.
        state_nxt = IDLE;
        gnt_nxt   = 3'b000;
        busyb_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 3'b000;
        busyb_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state <= IDLE;
      cnt   <= 4'd0;
      GNT   <= 3'b000;
      BUSYB <= 1'b1;
      LAST  <= 2'd2;
      TMO   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      GNT   <= gnt_nxt;
      BUSYB <= busyb_nxt;
      LAST  <= last_nxt;
      TMO   <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_scs8hd_arb3_rr.sv
// Bench for scs8hd_arb3_rr (MAX_HOLD=4). A cycle model pushes the expected
// outputs for every clock into a queue; each clock the oldest entry is popped
// and compared. Scenario tasks add directed checks against fixed constants.
module tb_scs8hd_arb3_rr;
  localparam int MH = 4;

  logic       CLK = 1'b0;
  logic       RESETB;
  logic [2:0] REQ;
  logic       B1, C1, DONE;
  logic [2:0] GNT;
  logic       BUSYB;
  logic [1:0] LAST;
  logic       TMO;

  scs8hd_arb3_rr #(.MAX_HOLD(MH)) u_dut (
    .CLK(CLK), .RESETB(RESETB), .REQ(REQ), .B1(B1), .C1(C1), .DONE(DONE),
    .GNT(GNT), .BUSYB(BUSYB), .LAST(LAST), .TMO(TMO)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [2:0] gnt;
    logic       busyb;
    logic [1:0] last;
    logic       tmo;
  } exp_t;
  exp_t sb[$];

  // Reference model state: 0 idle, 1 holding, 2 release.
  int         m_st, m_cnt, m_last, m_hold;
  logic [2:0] m_gnt;
  logic       m_tmo;

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_last = 2; m_hold = 0; m_gnt = 3'b000; m_tmo = 1'b0;
    sb.delete();
  endtask

  task automatic model_step();
    exp_t e;
    int   w;
    m_tmo = 1'b0;
    if (m_st == 0) begin
      w = -1;
      for (int k = 1; k <= 3; k++)
        if (w < 0 && REQ[(m_last + k) % 3]) w = (m_last + k) % 3;
      if (C1 && B1 && w >= 0) begin
        m_st = 1; m_hold = w; m_last = w; m_cnt = 0;
        m_gnt = 3'b000; m_gnt[w] = 1'b1;
      end
    end else if (m_st == 1) begin
      if (!C1) begin
        m_st = 0; m_gnt = 3'b000;
      end else if (DONE || !REQ[m_hold]) begin
        m_st = 2; m_gnt = 3'b000;
      end else if (m_cnt == MH - 1) begin
        m_st = 2; m_gnt = 3'b000; m_tmo = 1'b1;
      end else if (m_cnt < 15) begin
        m_cnt++;
      end
    end else begin
      m_st = 0; m_gnt = 3'b000;
    end
    e.gnt = m_gnt; e.busyb = (m_gnt == 3'b000); e.last = 2'(m_last); e.tmo = m_tmo;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e, a;
    model_step();
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    a = {GNT, BUSYB, LAST, TMO};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL tick t=%0t: got gnt=%b busyb=%b last=%0d tmo=%b, want gnt=%b busyb=%b last=%0d tmo=%b",
               $time, a.gnt, a.busyb, a.last, a.tmo, e.gnt, e.busyb, e.last, e.tmo);
    end
    vectors++;
    if ($countones(GNT) > 1) begin
      miscompares++;
      $display("FAIL onehot: gnt=%b, want at most one bit", GNT);
    end
  endtask

  task automatic apply_reset();
    RESETB = 1'b0; REQ = 3'b000; B1 = 1'b0; C1 = 1'b0; DONE = 1'b0;
    repeat (2) @(posedge CLK);
    model_reset();
    @(negedge CLK);
    RESETB = 1'b1;
  endtask

  task automatic check_idle_outs(input string name);
    vectors++;
    if (GNT !== 3'b000 || BUSYB !== 1'b1 || LAST !== 2'd2 || TMO !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b busyb=%b last=%0d tmo=%b, want 000/1/2/0",
               name, GNT, BUSYB, LAST, TMO);
    end
  endtask

  task automatic test_reset();
    RESETB = 1'b1; REQ = 3'b000; B1 = 1'b0; C1 = 1'b0; DONE = 1'b0;
    #3;
    RESETB = 1'b0;
    #1;
    check_idle_outs("reset_values");
    apply_reset();
    // Qualifiers low: nothing may be granted.
    REQ = 3'b111; C1 = 1'b0; B1 = 1'b1;
    repeat (2) tick();
    REQ = 3'b111; C1 = 1'b1; B1 = 1'b0;
    repeat (2) tick();
    REQ = 3'b000; C1 = 1'b1; B1 = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_priority();
    logic [2:0] seq [4];
    logic [1:0] lst [4];
    logic [2:0] exp_seq [4];
    logic [1:0] exp_lst [4];
    logic [2:0] prev;
    int         age, n;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_lst = '{2'd0, 2'd1, 2'd2, 2'd0};
    apply_reset();
    REQ = 3'b111; B1 = 1'b1; C1 = 1'b1;
    age = 0; n = 0; prev = 3'b000;
    for (int c = 0; c < 40 && n < 4; c++) begin
      DONE = (age == 1);
      tick();
      if (GNT != 3'b000 && prev == 3'b000) begin
        seq[n] = GNT; lst[n] = LAST; n++;
      end
      age  = (GNT != 3'b000) ? age + 1 : 0;
      prev = GNT;
    end
    DONE = 1'b0;
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL prio_count: got %0d grants, want 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (seq[i] !== exp_seq[i] || lst[i] !== exp_lst[i]) begin
          miscompares++;
          $display("FAIL prio_seq[%0d]: got gnt=%b last=%0d, want gnt=%b last=%0d",
                   i, seq[i], lst[i], exp_seq[i], exp_lst[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int  hold, tmo_cnt, phase;
    logic tmo_gnt_ok;
    apply_reset();
    REQ = 3'b010; B1 = 1'b1; C1 = 1'b1; DONE = 1'b0;
    hold = 0; tmo_cnt = 0; phase = 0; tmo_gnt_ok = 1'b1;
    for (int c = 0; c < 20 && phase < 2; c++) begin
      // A non-holder request appears mid-hold; it must not disturb the grant.
      REQ = (phase == 0 && hold > 0) ? 3'b110 : 3'b010;
      tick();
      if (TMO) begin
        tmo_cnt++;
        if (GNT !== 3'b000) tmo_gnt_ok = 1'b0;
      end
      if (phase == 0 && GNT == 3'b010) hold++;
      else if (phase == 0 && hold > 0) phase = 1;
      else if (phase == 1 && GNT == 3'b010) phase = 2;
    end
    vectors++;
    if (hold != MH) begin
      miscompares++;
      $display("FAIL tmo_hold: got %0d grant cycles, want %0d", hold, MH);
    end
    vectors++;
    if (tmo_cnt != 1 || !tmo_gnt_ok) begin
      miscompares++;
      $display("FAIL tmo_pulse: got %0d pulses (gnt clear=%b), want 1 with gnt clear", tmo_cnt, tmo_gnt_ok);
    end
    vectors++;
    if (phase != 2) begin
      miscompares++;
      $display("FAIL tmo_regrant: got phase %0d, want regrant of 010", phase);
    end
  endtask

  task automatic test_revoke();
    int extra;
    apply_reset();
    REQ = 3'b100; B1 = 1'b1; C1 = 1'b1; DONE = 1'b0;
    for (int i = 0; i < 5 && GNT !== 3'b100; i++) tick();
    vectors++;
    if (GNT !== 3'b100) begin
      miscompares++;
      $display("FAIL revoke_setup: got gnt=%b, want 100", GNT);
    end
    C1 = 1'b0;
    tick();
    vectors++;
    if (GNT !== 3'b000 || BUSYB !== 1'b1 || TMO !== 1'b0) begin
      miscompares++;
      $display("FAIL revoke: got gnt=%b busyb=%b tmo=%b, want 000/1/0", GNT, BUSYB, TMO);
    end
    extra = 0;
    repeat (4) begin
      tick();
      if (GNT !== 3'b000) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL revoke_hold: got %0d granted cycles, want 0", extra);
    end
  endtask

  task automatic test_b1_gating();
    int bad;
    apply_reset();
    REQ = 3'b001; C1 = 1'b1; B1 = 1'b0; DONE = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (GNT !== 3'b000) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL b1_block: got %0d granted cycles, want 0", bad);
    end
    B1 = 1'b1;
    tick();
    vectors++;
    if (GNT !== 3'b001) begin
      miscompares++;
      $display("FAIL b1_grant: got gnt=%b, want 001", GNT);
    end
    B1 = 1'b0; REQ = 3'b011;
    bad = 0;
    repeat (2) begin
      tick();
      if (GNT !== 3'b001) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL b1_hold: got %0d cycles without grant, want 0", bad);
    end
    REQ = 3'b001;
  endtask

  task automatic test_async_reset();
    apply_reset();
    REQ = 3'b001; B1 = 1'b1; C1 = 1'b1; DONE = 1'b0;
    repeat (2) tick();
    vectors++;
    if (GNT !== 3'b001) begin
      miscompares++;
      $display("FAIL areset_setup: got gnt=%b, want 001", GNT);
    end
    @(negedge CLK);
    RESETB = 1'b0;
    #1;
    check_idle_outs("areset_mid_hold");
    model_reset();
    #2;
    RESETB = 1'b1;
    tick();
    vectors++;
    if (GNT !== 3'b001 || LAST !== 2'd0) begin
      miscompares++;
      $display("FAIL areset_first_arb: got gnt=%b last=%0d, want 001/0", GNT, LAST);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    REQ = 3'b001; B1 = 1'b1; C1 = 1'b1; DONE = 1'b0;
    for (int i = 0; i < 5 && GNT !== 3'b001; i++) tick();
    repeat (MH - 1) tick();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    vectors++;
    if (GNT !== 3'b000 || TMO !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_done_tmo: got gnt=%b tmo=%b, want 000/0", GNT, TMO);
    end
    for (int i = 0; i < 6 && GNT !== 3'b001; i++) tick();
    tick();
    REQ = 3'b000;
    tick();
    vectors++;
    if (GNT !== 3'b000 || BUSYB !== 1'b1 || TMO !== 1'b0) begin
      miscompares++;
      $display("FAIL req_drop: got gnt=%b busyb=%b tmo=%b, want 000/1/0", GNT, BUSYB, TMO);
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_priority();
    test_timeout();
    test_revoke();
    test_b1_gating();
    test_async_reset();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
